usb_tx_ctrl: RTL and testbench



---
 rtl/usb_pkg.sv | 54 +++++
 rtl/usb_tx_encoder.sv | 104 ++++++++++
 rtl/usb_tx_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_usb_tx_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions for the transmit (and receive) path.
//   - tx_packet command codes (same encoding as the receiver's packet codes)
//   - SYNC and PID byte constants, all sent LSB first
//   - transmit FSM state type
//   - helpers: command-to-PID lookup and one-bit USB CRC16 step
package usb_pkg;

  localparam logic [2:0] PktNone  = 3'b000;
  localparam logic [2:0] PktData0 = 3'b001;
  localparam logic [2:0] PktData1 = 3'b100;
  localparam logic [2:0] PktAck   = 3'b010;
  localparam logic [2:0] PktNack  = 3'b011;
  localparam logic [2:0] PktStall = 3'b111;

  localparam logic [7:0] SyncByte = 8'h80;
  localparam logic [7:0] PidData0 = 8'hC3;
  localparam logic [7:0] PidData1 = 8'h4B;
  localparam logic [7:0] PidAck   = 8'hD2;
  localparam logic [7:0] PidNack  = 8'h5A;
  localparam logic [7:0] PidStall = 8'h1E;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StPid,
    StData,
    StCrcLo,
    StCrcHi,
    StEopSe0,
    StEopJ
  } tx_state_e;

  function automatic logic [7:0] pid_of(input logic [2:0] pkt);
    logic [7:0] pid;
    case (pkt)
      PktData0: pid = PidData0;
      PktData1: pid = PidData1;
      PktAck:   pid = PidAck;
      PktNack:  pid = PidNack;
      PktStall: pid = PidStall;
      default:  pid = 8'h00;
    endcase
    return pid;
  endfunction

  // Reflected form of poly 0x8005, one data bit per call.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic [15:0] nxt;
    nxt = {1'b0, crc[15:1]};
    if (crc[0] ^ b) nxt = nxt ^ 16'hA001;
    return nxt;
  endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// Line encoder for the USB transmitter: bit-time counter, bit stuffing and NRZI.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   busy          a packet is in progress (counters run)
//   serial        SYNC..CRC_HI: data_bit is serialised with stuffing/NRZI
//   se0           drive SE0 (EOP)
//   data_bit      current bit from the FSM shifter
//   bit_strobe    last cycle of any bit time
//   bit_accept    last cycle of a data bit (not a stuff bit); FSM advances its shifter
//   data_start    first cycle of a data bit (not a stuff bit)
//   stuff_next    the current data bit will be followed by a stuff bit
//   dp, dm        pad drive; J when neither serial nor se0
module usb_tx_encoder #(
  parameter int unsigned CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic serial,
  input  logic se0,
  input  logic data_bit,
  output logic bit_strobe,
  output logic bit_accept,
  output logic data_start,
  output logic stuff_next,
  output logic dp,
  output logic dm
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      ones_q, ones_d;
  logic            stuff_q, stuff_d;
  logic            level_q, level_d;  // line level of the previous bit, 1 = J
  logic            cur_level;

  assign bit_strobe = busy && (cnt_q == LastCnt);
  assign bit_accept = serial && bit_strobe && !stuff_q;
  assign data_start = serial && !stuff_q && (cnt_q == '0);
  assign stuff_next = serial && !stuff_q && data_bit && (ones_q == 3'd5);

  // A stuff bit is a 0, so it always toggles.
  assign cur_level = (stuff_q || !data_bit) ? ~level_q : level_q;

  always_comb begin
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    stuff_d = stuff_q;
    level_d = level_q;
    if (!busy) begin
      cnt_d   = '0;
      ones_d  = '0;
      stuff_d = 1'b0;
      level_d = 1'b1;
    end else begin
      cnt_d = bit_strobe ? '0 : cnt_q + 1'b1;
      if (serial && bit_strobe) begin
        level_d = cur_level;
        if (stuff_q) begin
          stuff_d = 1'b0;
          ones_d  = '0;
        end else if (data_bit) begin
          if (ones_q == 3'd5) begin
            stuff_d = 1'b1;
            ones_d  = '0;
          end else begin
            ones_d = ones_q + 3'd1;
          end
        end else begin
          ones_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ones_q  <= '0;
      stuff_q <= 1'b0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      stuff_q <= stuff_d;
      level_q <= level_d;
    end
  end

  always_comb begin
    dp = 1'b1;
    dm = 1'b0;
    if (se0) begin
      dp = 1'b0;
      dm = 1'b0;
    end else if (serial) begin
      dp = cur_level;
      dm = ~cur_level;
    end
  end

endmodule

// File: rtl/usb_tx_ctrl.sv
// USB full-speed packet transmitter: SYNC, PID, FIFO payload, CRC16, EOP.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tx_packet           command (000 none, 001 DATA0, 100 DATA1, 010 ACK, 011 NACK, 111 STALL)
//   tx_packet_data      FIFO read data, valid the cycle after get_tx_packet_data
//   buffer_occupancy    FIFO byte count, sampled as payload length at start
//   get_tx_packet_data  one-cycle FIFO pop strobe
//   dp_out, dm_out      pad drive
//   tx_transfer_active  packet on the wire
//   tx_error            one-cycle pulse on a rejected command
// Build option: define USB_TX_CRC16_EN to send the real CRC16; otherwise both CRC bytes are 00.
module usb_tx_ctrl
  import usb_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] tx_packet,
  input  logic [7:0] tx_packet_data,
  input  logic [6:0] buffer_occupancy,
  output logic       get_tx_packet_data,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);

  tx_state_e   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  pid_q, pid_d;
  logic [2:0]  idx_q, idx_d;
  logic [6:0]  left_q, left_d;     // payload bytes not yet popped
  logic        fetched_q, fetched_d;  // next payload byte popped during this byte
  logic        is_data_q, is_data_d;
  logic        tail_q, tail_d;     // sending the stuff bit owed after the last bit
  logic        get_q;
  logic        err_q, err_d;
  logic        last_bit;

  logic cmd_data, cmd_hs, too_long, start;
  logic busy, serial, se0;
  logic bit_strobe, bit_accept, data_start, stuff_next;
  logic [7:0] fifo_byte, crc_lo, crc_hi;

  assign cmd_data = (tx_packet == PktData0) || (tx_packet == PktData1);
  assign cmd_hs   = (tx_packet == PktAck) || (tx_packet == PktNack) || (tx_packet == PktStall);
  assign too_long = cmd_data && (32'(buffer_occupancy) > MAX_PAYLOAD);
  assign start    = (state_q == StIdle) && (cmd_data || cmd_hs) && !too_long;
  assign err_d    = (state_q == StIdle) && (tx_packet != PktNone) && !start;

  assign busy   = (state_q != StIdle);
  assign serial = (state_q == StSync) || (state_q == StPid) || (state_q == StData) ||
                  (state_q == StCrcLo) || (state_q == StCrcHi);
  assign se0    = (state_q == StEopSe0);

  assign get_tx_packet_data = ((state_q == StPid) || (state_q == StData)) && (idx_q == 3'd7) &&
                              data_start && (left_q != '0);

  // With CLKS_PER_BIT=2 the capture and the byte boundary share a cycle, so bypass the holder.
  assign fifo_byte = get_q ? tx_packet_data : hold_q;

  assign tx_transfer_active = busy;
  assign tx_error           = err_q;

`ifdef USB_TX_CRC16_EN
  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (start) begin
      crc_d = 16'hFFFF;
    end else if (bit_accept && (state_q == StData)) begin
      crc_d = crc16_step(crc_q, shift_q[0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= 16'hFFFF;
    else     crc_q <= crc_d;
  end

  // crc_d so the final payload bit is folded in at the DATA -> CRC_LO boundary.
  assign crc_lo = ~crc_d[7:0];
  assign crc_hi = ~crc_q[15:8];
`else
  assign crc_lo = 8'h00;
  assign crc_hi = 8'h00;
`endif

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    pid_d     = pid_q;
    idx_d     = idx_q;
    left_d    = left_q;
    fetched_d = fetched_q;
    is_data_d = is_data_q;
    tail_d    = tail_q;
    last_bit  = 1'b0;

    if (get_q) hold_d = tx_packet_data;
    if (get_tx_packet_data) begin
      left_d    = left_q - 7'd1;
      fetched_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StSync;
          shift_d   = SyncByte;
          pid_d     = pid_of(tx_packet);
          idx_d     = '0;
          is_data_d = cmd_data;
          left_d    = cmd_data ? buffer_occupancy : 7'd0;
          fetched_d = 1'b0;
          tail_d    = 1'b0;
        end
      end
      StSync, StPid, StData, StCrcLo, StCrcHi: begin
        if (tail_q) begin
          if (bit_strobe) begin
            state_d = StEopSe0;
            tail_d  = 1'b0;
          end
        end else if (bit_accept) begin
          idx_d   = idx_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            case (state_q)
              StSync: begin
                state_d = StPid;
                shift_d = pid_q;
              end
              StPid, StData: begin
                if (!is_data_q) begin
                  last_bit = 1'b1;
                end else if (fetched_q) begin
                  state_d   = StData;
                  shift_d   = fifo_byte;
                  fetched_d = 1'b0;
                end else begin
                  state_d = StCrcLo;
                  shift_d = crc_lo;
                end
              end
              StCrcLo: begin
                state_d = StCrcHi;
                shift_d = crc_hi;
              end
              default: last_bit = 1'b1;
            endcase
            if (last_bit) begin
              if (stuff_next) tail_d = 1'b1;
              else            state_d = StEopSe0;
            end
          end
        end
      end
      StEopSe0: begin
        if (bit_strobe) begin
          if (idx_q == 3'd1) begin
            state_d = StEopJ;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StEopJ: begin
        if (bit_strobe) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      hold_q    <= '0;
      pid_q     <= '0;
      idx_q     <= '0;
      left_q    <= '0;
      fetched_q <= 1'b0;
      is_data_q <= 1'b0;
      tail_q    <= 1'b0;
      get_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      pid_q     <= pid_d;
      idx_q     <= idx_d;
      left_q    <= left_d;
      fetched_q <= fetched_d;
      is_data_q <= is_data_d;
      tail_q    <= tail_d;
      get_q     <= get_tx_packet_data;
      err_q     <= err_d;
    end
  end

  usb_tx_encoder #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_encoder (
    .clk       (clk),
    .rst       (rst),
    .busy      (busy),
    .serial    (serial),
    .se0       (se0),
    .data_bit  (shift_q[0]),
    .bit_strobe(bit_strobe),
    .bit_accept(bit_accept),
    .data_start(data_start),
    .stuff_next(stuff_next),
    .dp        (dp_out),
    .dm        (dm_out)
  );

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// Bench for usb_tx_ctrl: a bit-level line model fills a per-cycle scoreboard of
// {tx_transfer_active, dp, dm}; each scenario pops and compares it cycle by cycle.
module tb_usb_tx_ctrl;

  localparam int Cpb    = 8;
  localparam int MaxPay = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] tx_packet = 3'b000;
  logic [7:0] tx_packet_data = 8'h00;
  logic [6:0] buffer_occupancy = 7'd0;
  logic       get_tx_packet_data, dp_out, dm_out, tx_transfer_active, tx_error;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  logic [7:0] fifo_q[$];
  logic [7:0] pay_q[$];
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  usb_tx_ctrl #(
    .CLKS_PER_BIT(Cpb),
    .MAX_PAYLOAD (MaxPay)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .tx_packet         (tx_packet),
    .tx_packet_data    (tx_packet_data),
    .buffer_occupancy  (buffer_occupancy),
    .get_tx_packet_data(get_tx_packet_data),
    .dp_out            (dp_out),
    .dm_out            (dm_out),
    .tx_transfer_active(tx_transfer_active),
    .tx_error          (tx_error)
  );

  // FIFO: a pop seen in cycle G presents the byte for cycle G+1.
  initial begin
    forever begin
      @(negedge clk);
      if (get_tx_packet_data === 1'b1) begin
        pops++;
        if (fifo_q.size() > 0) tx_packet_data = fifo_q.pop_front();
        else                   tx_packet_data = 8'h00;
      end
    end
  end

  task automatic push_bits(input logic [7:0] b, inout int ones, inout logic level);
    for (int i = 0; i < 8; i++) begin
      if (!b[i]) level = ~level;
      repeat (Cpb) exp_q.push_back({1'b1, level, ~level});
      if (b[i]) begin
        ones++;
        if (ones == 6) begin
          level = ~level;
          repeat (Cpb) exp_q.push_back({1'b1, level, ~level});
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
  endtask

  task automatic expect_packet(input logic [7:0] pid, input logic is_data);
    int          ones;
    logic        level;
    logic [15:0] crc_out;
`ifdef USB_TX_CRC16_EN
    logic [15:0] crc;
    crc = 16'hFFFF;
`endif
    ones    = 0;
    level   = 1'b1;
    crc_out = 16'h0000;
    push_bits(8'h80, ones, level);
    push_bits(pid, ones, level);
    if (is_data) begin
      foreach (pay_q[k]) begin
        push_bits(pay_q[k], ones, level);
`ifdef USB_TX_CRC16_EN
        for (int i = 0; i < 8; i++) begin
          if (crc[0] ^ pay_q[k][i]) crc = (crc >> 1) ^ 16'hA001;
          else                      crc = crc >> 1;
        end
`endif
      end
`ifdef USB_TX_CRC16_EN
      crc_out = ~crc;
`endif
      push_bits(crc_out[7:0], ones, level);
      push_bits(crc_out[15:8], ones, level);
    end
    repeat (2 * Cpb) exp_q.push_back(3'b100);
    repeat (Cpb) exp_q.push_back(3'b110);
    exp_q.push_back(3'b010);
  endtask

  task automatic load_payload(input int n);
    logic [7:0] b;
    pay_q.delete();
    fifo_q.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      pay_q.push_back(b);
      fifo_q.push_back(b);
    end
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [6:0] occ);
    @(negedge clk);
    tx_packet        = cmd;
    buffer_occupancy = occ;
    @(posedge clk);
    #1 tx_packet = 3'b000;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (dp_out !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b want=1", dp_out); end
    total++; if (dm_out !== 1'b0) begin bad++; $display("FAIL reset_dm got=%b want=0", dm_out); end
    total++; if (tx_transfer_active !== 1'b0) begin
      bad++; $display("FAIL reset_active got=%b want=0", tx_transfer_active);
    end
    total++; if (tx_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", tx_error); end
    total++; if (get_tx_packet_data !== 1'b0) begin
      bad++; $display("FAIL reset_get got=%b want=0", get_tx_packet_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ack;
    int c, n_act;
    logic [2:0] e;
    pay_q.delete();
    exp_q.delete();
    expect_packet(8'hD2, 1'b0);
    pops  = 0;
    n_act = 0;
    c     = 0;
    send_cmd(3'b010, 7'd0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (tx_transfer_active === 1'b1) n_act++;
      total++;
      if ({tx_transfer_active, dp_out, dm_out} !== e) begin
        bad++; $display("FAIL ack_line cyc=%0d got=%b want=%b", c, {tx_transfer_active, dp_out, dm_out}, e);
      end
      c++;
    end
    total++; if (n_act !== 152) begin bad++; $display("FAIL ack_active_len got=%0d want=152", n_act); end
    total++; if (pops !== 0) begin bad++; $display("FAIL ack_pops got=%0d want=0", pops); end
  endtask

  task automatic test_data0_empty;
    int c;
    logic [2:0] e;
    pay_q.delete();
    fifo_q.delete();
    exp_q.delete();
    expect_packet(8'hC3, 1'b1);
    pops = 0;
    c    = 0;
    send_cmd(3'b001, 7'd0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({tx_transfer_active, dp_out, dm_out} !== e) begin
        bad++; $display("FAIL empty_line cyc=%0d got=%b want=%b", c, {tx_transfer_active, dp_out, dm_out}, e);
      end
      c++;
    end
    total++; if (pops !== 0) begin bad++; $display("FAIL empty_pops got=%0d want=0", pops); end
  endtask

  task automatic test_stuff;
    int c;
    logic [2:0] e, dps;
    pay_q.delete();
    fifo_q.delete();
    exp_q.delete();
    pay_q.push_back(8'hFF);
    fifo_q.push_back(8'hFF);
    expect_packet(8'hC3, 1'b1);
    pops = 0;
    c    = 0;
    dps  = 3'b000;
    send_cmd(3'b001, 7'd1);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (c == 19 * Cpb + Cpb / 2) dps[0] = dp_out;
      if (c == 20 * Cpb + Cpb / 2) dps[1] = dp_out;
      if (c == 21 * Cpb + Cpb / 2) dps[2] = dp_out;
      total++;
      if ({tx_transfer_active, dp_out, dm_out} !== e) begin
        bad++; $display("FAIL stuff_line cyc=%0d got=%b want=%b", c, {tx_transfer_active, dp_out, dm_out}, e);
      end
      c++;
    end
    // Wire bits 19, 20 (stuffed 0), 21: K, J, J.
    total++; if (dps !== 3'b110) begin bad++; $display("FAIL stuff_bit dp=%b want=110", dps); end
    total++; if (pops !== 1) begin bad++; $display("FAIL stuff_pops got=%0d want=1", pops); end
  endtask

  task automatic test_error;
    logic [2:0] cmds[2];
    logic [6:0] occs[2];
    cmds[0] = 3'b110; occs[0] = 7'd0;
    cmds[1] = 3'b100; occs[1] = 7'd65;
    for (int k = 0; k < 2; k++) begin
      send_cmd(cmds[k], occs[k]);
      @(negedge clk);
      total++; if (tx_error !== 1'b1) begin bad++; $display("FAIL err_pulse k=%0d got=%b want=1", k, tx_error); end
      total++; if ({tx_transfer_active, dp_out, dm_out} !== 3'b010) begin
        bad++; $display("FAIL err_line k=%0d got=%b want=010", k, {tx_transfer_active, dp_out, dm_out});
      end
      @(negedge clk);
      total++; if (tx_error !== 1'b0) begin bad++; $display("FAIL err_width k=%0d got=%b want=0", k, tx_error); end
      total++; if ({tx_transfer_active, dp_out, dm_out} !== 3'b010) begin
        bad++; $display("FAIL err_idle k=%0d got=%b want=010", k, {tx_transfer_active, dp_out, dm_out});
      end
    end
  endtask

  task automatic test_reset_mid;
    int c, n_act, pops_r;
    logic [2:0] e;
    exp_q.delete();
    load_payload(10);
    expect_packet(8'h4B, 1'b1);
    pops = 0;
    send_cmd(3'b100, 7'd10);
    for (c = 0; c < 46 * Cpb; c++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({tx_transfer_active, dp_out, dm_out} !== e) begin
        bad++; $display("FAIL rmid_line cyc=%0d got=%b want=%b", c, {tx_transfer_active, dp_out, dm_out}, e);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    total++; if ({tx_transfer_active, dp_out, dm_out} !== 3'b010) begin
      bad++; $display("FAIL rmid_after got=%b want=010", {tx_transfer_active, dp_out, dm_out});
    end
    total++; if (get_tx_packet_data !== 1'b0) begin
      bad++; $display("FAIL rmid_get got=%b want=0", get_tx_packet_data);
    end
    pops_r = pops;
    rst    = 1'b0;
    n_act  = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_transfer_active !== 1'b0) n_act++;
    end
    total++; if (n_act !== 0) begin bad++; $display("FAIL rmid_active got=%0d want=0", n_act); end
    total++; if (pops !== pops_r) begin bad++; $display("FAIL rmid_pops got=%0d want=%0d", pops, pops_r); end
    exp_q.delete();
    fifo_q.delete();
    pay_q.delete();
    expect_packet(8'hD2, 1'b0);
    c = 0;
    send_cmd(3'b010, 7'd0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({tx_transfer_active, dp_out, dm_out} !== e) begin
        bad++; $display("FAIL rmid_ack cyc=%0d got=%b want=%b", c, {tx_transfer_active, dp_out, dm_out}, e);
      end
      c++;
    end
  endtask

  task automatic test_busy_ignored;
    int c, n_act;
    logic [2:0] e;
    exp_q.delete();
    load_payload(3);
    expect_packet(8'h4B, 1'b1);
    pops = 0;
    c    = 0;
    send_cmd(3'b100, 7'd3);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({tx_transfer_active, dp_out, dm_out} !== e) begin
        bad++; $display("FAIL busy_line cyc=%0d got=%b want=%b", c, {tx_transfer_active, dp_out, dm_out}, e);
      end
      if (c == 60) tx_packet = 3'b100;
      if (c == 61) tx_packet = 3'b000;
      c++;
    end
    n_act = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_transfer_active !== 1'b0) n_act++;
    end
    total++; if (n_act !== 0) begin bad++; $display("FAIL busy_second got=%0d want=0", n_act); end
    total++; if (pops !== 3) begin bad++; $display("FAIL busy_pops got=%0d want=3", pops); end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_data0_empty();
    test_stuff();
    test_error();
    test_reset_mid();
    test_busy_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
